// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, sequencer state encodings and ALU opcodes for the calculator datapath.
package calc_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int OPW_DEF = 3;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HAVE_A = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_PASS
  } opcode_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer followed by a rising-edge detector giving one pulse per press.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], d_i};
  assign pulse_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects two operands and an opcode from switches via enter presses,
// then offers them downstream with a valid/ready handshake.
module operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [OPW-1:0]   op_sel,
  input  logic             enter,
  input  logic             clear,
  input  logic             ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [OPW-1:0]   op,
  output logic             valid,
  output logic [1:0]       state
);
  logic enter_p, clear_p;
  logic [WIDTH-1:0] sw_s1_q, sw_s2_q, a_q, a_d, b_q, b_d;
  logic [OPW-1:0] op_s1_q, op_s2_q, op_q, op_d;
  logic [1:0] state_q, state_d;
  sync_edge u_enter (.clk(clk), .rst_n(rst_n), .d_i(enter), .pulse_o(enter_p));
  sync_edge u_clear (.clk(clk), .rst_n(rst_n), .d_i(clear), .pulse_o(clear_p));
  // Switch data gets the same two-flop depth as enter so the captured value matches the press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      op_s1_q <= '0;
      op_s2_q <= '0;
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      op_s1_q <= op_sel;
      op_s2_q <= op_s1_q;
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
    end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    if (clear_p) begin
      state_d = ST_IDLE;
      a_d = '0;
      b_d = '0;
      op_d = '0;
    end else
      case (state_q)
        ST_IDLE: if (enter_p) begin
          a_d = sw_s2_q;
          state_d = ST_HAVE_A;
        end
        ST_HAVE_A: if (enter_p) begin
          b_d = sw_s2_q;
          op_d = op_s2_q;
          state_d = ST_READY;
        end
        ST_READY: state_d = ready ? ST_IDLE : ST_READY;
        default: state_d = ST_IDLE;
      endcase
  end
  assign a = a_q;
  assign b = b_q;
  assign op = op_q;
  assign valid = state_q == ST_READY;
  assign state = state_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed stimulus with a transfer scoreboard checked by a separate monitor.
module tb_operand_sequencer;
  logic clk = 0, rst_n = 0, enter = 0, clear = 0, ready = 0;
  logic [7:0] sw = '0;
  logic [2:0] op_sel = '0;
  logic [7:0] a, b;
  logic [2:0] op;
  logic valid;
  logic [1:0] state;
  int total = 0, bad = 0;
  logic [18:0] exp_q[$];

  operand_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sel(op_sel), .enter(enter), .clear(clear),
    .ready(ready), .a(a), .b(b), .op(op), .valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, want, $time);
    end
  endtask

  task automatic press_enter();
    enter = 1;
    repeat (2) @(negedge clk);
    enter = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_clear();
    clear = 1;
    repeat (2) @(negedge clk);
    clear = 0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every accepted transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    #1;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected got=%0h want=none @%0t", {a, b, op}, $time);
      end else chk("xfer", {a, b, op}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1;
    @(negedge clk);
    // Basic two-operand load and single-cycle transfer
    sw = 8'hA5;
    press_enter();
    chk("s1_state_a", state, 1);
    chk("s1_a", a, 8'hA5);
    sw = 8'h3C;
    op_sel = 3'd2;
    exp_q.push_back({8'hA5, 8'h3C, 3'd2});
    press_enter();
    chk("s1_state_rdy", state, 2);
    chk("s1_valid", valid, 1);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("s1_idle", state, 0);
    chk("s1_valid_lo", valid, 0);
    chk("s1_hold_a", a, 8'hA5);
    chk("s1_hold_b", b, 8'h3C);
    chk("s1_hold_op", op, 2);
    // Stall in READY with extra presses that must be ignored
    sw = 8'h11;
    op_sel = 3'd0;
    press_enter();
    sw = 8'h22;
    op_sel = 3'd5;
    exp_q.push_back({8'h11, 8'h22, 3'd5});
    press_enter();
    repeat (10) @(negedge clk);
    sw = 8'h77;
    op_sel = 3'd7;
    press_enter();
    sw = 8'h99;
    press_enter();
    chk("s2_valid", valid, 1);
    chk("s2_state", state, 2);
    chk("s2_a", a, 8'h11);
    chk("s2_b", b, 8'h22);
    chk("s2_op", op, 5);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("s2_idle", state, 0);
    // Clear coinciding with enter in HAVE_A
    sw = 8'h11;
    press_enter();
    chk("s3_state_a", state, 1);
    chk("s3_a", a, 8'h11);
    sw = 8'h33;
    enter = 1;
    clear = 1;
    repeat (2) @(negedge clk);
    enter = 0;
    clear = 0;
    repeat (4) @(negedge clk);
    chk("s3_idle", state, 0);
    chk("s3_a0", a, 0);
    chk("s3_b0", b, 0);
    chk("s3_op0", op, 0);
    // Held button yields a single capture
    sw = 8'hFF;
    enter = 1;
    repeat (50) @(negedge clk);
    enter = 0;
    repeat (4) @(negedge clk);
    chk("s4_state", state, 1);
    chk("s4_a", a, 8'hFF);
    chk("s4_valid", valid, 0);
    press_clear();
    chk("s4_clr_state", state, 0);
    chk("s4_clr_a", a, 0);
    // Capture latency: enter sampled at edge k updates a at k+2
    sw = 8'h5A;
    enter = 1;
    @(negedge clk);
    chk("lat_k", a, 0);
    @(negedge clk);
    chk("lat_k1", a, 0);
    @(negedge clk);
    chk("lat_k2", a, 8'h5A);
    chk("lat_state", state, 1);
    enter = 0;
    repeat (4) @(negedge clk);
    // Asynchronous reset while in READY
    sw = 8'hC3;
    op_sel = 3'd1;
    press_enter();
    chk("s6_ready", state, 2);
    #2 rst_n = 0;
    #1;
    chk("s6_state", state, 0);
    chk("s6_a", a, 0);
    chk("s6_b", b, 0);
    chk("s6_op", op, 0);
    chk("s6_valid", valid, 0);
    // Enter already held when reset releases gives exactly one capture
    @(negedge clk);
    sw = 8'h44;
    enter = 1;
    rst_n = 1;
    repeat (8) @(negedge clk);
    enter = 0;
    repeat (4) @(negedge clk);
    chk("s7_state", state, 1);
    chk("s7_a", a, 8'h44);
    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter OPW, default 3: opcode width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sw, input, WIDTH: operand value from switches, asynchronous to clk.
REQ-006 SHALL have port op_sel, input, OPW: opcode from switches, asynchronous to clk.
REQ-007 SHALL have port enter, input, 1: load button, level, asynchronous.
REQ-008 SHALL have port clear, input, 1: clear button, level, asynchronous.
REQ-009 SHALL have port ready, input, 1: downstream operation stage can accept operands.
REQ-010 SHALL have port a, output, WIDTH: latched first operand.
REQ-011 SHALL have port b, output, WIDTH: latched second operand.
REQ-012 SHALL have port op, output, OPW: latched opcode.
REQ-013 SHALL have port valid, output, 1: a/b/op are complete and offered downstream.
REQ-014 SHALL have port state, output, 2: current FSM state, for LEDs.

Function
REQ-015 SHALL pass enter and clear through separate 2-flop synchronizers, then a rising-edge detector (one extra flop), giving a 1-cycle pulse per press.
REQ-016 SHALL, for enter first sampled high at edge k, perform the resulting capture at edge k+2.
REQ-017 SHALL implement states IDLE=2'b00, HAVE_A=2'b01, READY=2'b10; 2'b11 unused, and SHALL return to IDLE from it on the next edge.
REQ-018 SHALL, in IDLE on an enter pulse, capture the synchronized sw into a and go to HAVE_A.
REQ-019 SHALL, in HAVE_A on an enter pulse, capture sw into b and op_sel into op, then go to READY.
REQ-020 SHALL register sw and op_sel through the same 2-flop synchronizer depth as enter, so the captured value matches the switches at the press.
REQ-021 SHALL drive valid high exactly while in READY.
REQ-022 SHALL, in READY, complete a transfer on any edge with valid=1 and ready=1, then go to IDLE.
REQ-023 SHALL keep a, b and op unchanged after a transfer until overwritten.
REQ-024 SHALL ignore enter pulses in READY; operands SHALL remain stable while valid=1.
REQ-025 SHALL, on a clear pulse in any state, go to IDLE and zero a, b and op, with valid low on the next cycle.
REQ-026 SHALL give clear priority over enter and transfer when they coincide.
REQ-027 SHALL generate only one pulse for a held button; a new pulse requires release for at least 1 synchronized cycle.

Reset
REQ-028 SHALL, while rst_n=0, force immediately: state=IDLE, a=0, b=0, op=0, valid=0, and all synchronizer and edge flops to 0.
REQ-029 SHALL, when reset is released with enter already held, produce one pulse (edge detector starts at 0).
REQ-030 SHALL, on reset mid-operation (HAVE_A or READY), discard all operands.

Structure
REQ-031 SHALL take state encodings and the WIDTH/OPW defaults from a shared calc_pkg; opcode values SHALL also live there for the downstream ALU.
REQ-032 SHALL contain one sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated for enter and for clear.
REQ-033 SHALL contain no arithmetic; all operation logic stays downstream.

Verification
REQ-034 Bench SHALL cover: sw=8'hA5, press; sw=8'h3C, op_sel=3'd2, press, ready=1 -> valid 1 cycle, a=A5, b=3C, op=2, then state=IDLE.
REQ-035 Bench SHALL cover: reach READY with ready=0 for 10 cycles, press enter twice with sw changed -> valid held, a/b/op unchanged; ready=1 -> transfer.
REQ-036 Bench SHALL cover: in HAVE_A (a=8'h11), pulse clear and enter the same cycle -> IDLE, a=0, no b captured.
REQ-037 Bench SHALL cover: hold enter 50 cycles in IDLE with sw=8'hFF -> exactly one capture, state=HAVE_A, a=FF.
REQ-038 Bench SHALL cover: rst_n low in READY, asynchronously between edges -> outputs 0 and state IDLE before the next edge.
REQ-039 Bench SHALL cover: enter high at edge k -> a updated at edge k+2, not at k+1.
